seg_source: RTL
===============

SEG_SOURCE -- requirements
Module: seg_source

Interface
REQ-001 Parameter: DWELL, default 25000000, number of clk cycles each byte stays displayed (minimum 2).
REQ-002 Port: clk  input  1  the block's only clock; every register updates on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset.
REQ-004 Port: wr_en  input  1  one-cycle write strobe from the memory stage for the display register address.
REQ-005 Port: wr_data  input  16  value to display; sampled when wr_en=1.
REQ-006 Port: freeze  input  1  when high, the dwell timer and the displayed byte are held.
REQ-007 Port: disp_data  output  8  byte driven to the downstream two-digit hex decoder's 8-bit input.
REQ-008 Port: disp_hi  output  1  0 = low byte shown, 1 = high byte shown.
REQ-009 Port: wr_ack  output  1  one-cycle pulse confirming a write was captured.

Function
REQ-010 The block SHALL hold a 16-bit value register, a 3-state FSM (IDLE, SHOW_LO, SHOW_HI) and a dwell counter of width ceil(log2(DWELL)).
REQ-011 In IDLE, disp_data SHALL be 8'h00, disp_hi SHALL be 0, and the counter SHALL stay at 0.
REQ-012 On any edge with wr_en=1, the block SHALL do all of the following on that same edge, in every state, regardless of freeze: capture wr_data, enter SHOW_LO, clear the counter, load disp_data with wr_data[7:0], and set wr_ack=1 for exactly the following cycle.
REQ-013 In SHOW_LO/SHOW_HI with freeze=0 and wr_en=0, the counter SHALL increment each cycle.
REQ-014 When the counter equals DWELL-1, the block SHALL clear the counter and toggle the state on that edge (SHOW_LO->SHOW_HI, SHOW_HI->SHOW_LO). Each byte is therefore shown for exactly DWELL cycles.
REQ-015 disp_data SHALL be registered and SHALL equal value[7:0] in SHOW_LO and value[15:8] in SHOW_HI. disp_hi SHALL be 1 only in SHOW_HI.
REQ-016 With freeze=1 and wr_en=0, the state, counter, disp_data and disp_hi SHALL hold their values.
REQ-017 When wr_en=1 coincides with counter=DWELL-1, the write SHALL take priority: the block enters SHOW_LO with the counter at 0.
REQ-018 Back-to-back writes SHALL each be captured. The last write wins, and wr_ack SHALL stay high for each cycle that follows a write.
REQ-019 The block SHALL never return to IDLE except through reset.

Reset
REQ-020 On assertion of rst (rst=0), asynchronously: state=IDLE, value=16'h0000, counter=0, disp_data=8'h00, disp_hi=0, wr_ack=0.
REQ-021 A write in the cycle reset deasserts SHALL be captured normally. Reset asserted mid-dwell SHALL discard the value and the phase.

Structure
REQ-022 A shared package SHALL hold the FSM state encoding constants and the DWELL default.
REQ-023 The dwell counter with its wrap detect SHALL be a sub-module named dwell_timer, with ports clk, rst, clr, en, and wrap.
REQ-024 The downstream hex decoder SHALL be instantiated outside this block and connected only through disp_data.

Verification (benches run with DWELL=4)
REQ-025 Reset, then 10 idle cycles -> disp_data=8'h00, disp_hi=0, wr_ack never high.
REQ-026 Write 16'hA53C -> next cycle disp_data=8'h3C and wr_ack=1 for 1 cycle; after 4 cycles disp_data=8'hA5 and disp_hi=1; after 4 more cycles disp_data=8'h3C again.
REQ-027 Write 16'h1234, set freeze=1 during the high phase for 10 cycles -> disp_data stays 8'h12; after freeze drops, the remaining dwell completes, then disp_data=8'h34.
REQ-028 While showing the high byte of 16'h1234, write 16'hBEEF on the wrap cycle -> disp_data=8'hEF, disp_hi=0, and a full 4-cycle dwell follows.
REQ-029 Writes 16'h0001 then 16'h0002 on consecutive edges -> wr_ack high for 2 cycles, disp_data=8'h02.
REQ-030 Pulse rst low mid-dwell after writing 16'hFFFF -> outputs return immediately to 8'h00, disp_hi=0, state IDLE, with no toggling afterwards.

Source files
------------

// File: rtl/seg_source_pkg.sv
// Shared types and defaults for the two-byte seven-segment source.
package seg_source_pkg;

  localparam int unsigned DWELL_DEFAULT = 25000000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHOW_LO = 2'd1,
    SHOW_HI = 2'd2
  } state_e;

endpackage

// File: rtl/seg_source_dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while enabled and flags the last cycle.
module dwell_timer
  import seg_source_pkg::*;
#(
  parameter int unsigned DWELL = DWELL_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  localparam int unsigned W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [W-1:0] LAST = W'(DWELL - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // A clear always wins over counting, so a write restarts the dwell.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end
  end

  assign wrap = en && !clr && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_source.sv
// Holds a 16-bit value and alternates its low/high byte onto an 8-bit display bus.
module seg_source
  import seg_source_pkg::*;
#(
  parameter int unsigned DWELL = DWELL_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic        freeze,
  output logic [7:0]  disp_data,
  output logic        disp_hi,
  output logic        wr_ack
);

  state_e      state_q, state_d;
  logic [15:0] value_q, value_d;
  logic [7:0]  disp_data_q, disp_data_d;
  logic        disp_hi_q, disp_hi_d;
  logic        wr_ack_q, wr_ack_d;
  logic        timer_en;
  logic        timer_wrap;

  assign timer_en = (state_q != IDLE) && !freeze;

  dwell_timer #(
    .DWELL(DWELL)
  ) u_dwell_timer (
    .clk (clk),
    .rst (rst),
    .clr (wr_en),
    .en  (timer_en),
    .wrap(timer_wrap)
  );

  // A write overrides everything, including a coincident wrap or freeze.
  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    disp_data_d = disp_data_q;
    disp_hi_d   = disp_hi_q;
    wr_ack_d    = wr_en;
    if (wr_en) begin
      value_d     = wr_data;
      state_d     = SHOW_LO;
      disp_data_d = wr_data[7:0];
      disp_hi_d   = 1'b0;
    end else if (timer_wrap) begin
      case (state_q)
        SHOW_LO: begin
          state_d     = SHOW_HI;
          disp_data_d = value_q[15:8];
          disp_hi_d   = 1'b1;
        end
        SHOW_HI: begin
          state_d     = SHOW_LO;
          disp_data_d = value_q[7:0];
          disp_hi_d   = 1'b0;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      value_q     <= 16'h0000;
      disp_data_q <= 8'h00;
      disp_hi_q   <= 1'b0;
      wr_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      disp_data_q <= disp_data_d;
      disp_hi_q   <= disp_hi_d;
      wr_ack_q    <= wr_ack_d;
    end
  end

  assign disp_data = disp_data_q;
  assign disp_hi   = disp_hi_q;
  assign wr_ack    = wr_ack_q;

endmodule
